// File: rtl/ppu_write_merger.sv
// Merges per-core pixel streams through per-core FIFOs into a single
// round-robin Avalon-MM framebuffer write master.
module ppu_write_merger #(
  parameter int unsigned CORES_COUNT   = 10,
  parameter int unsigned COLOR_WIDTH   = 16,
  parameter int unsigned BUFFER_ADDR_W = 32,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter logic [31:0] FB_BASE       = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [COLOR_WIDTH-1:0]   in_data    [CORES_COUNT],
  input  logic [BUFFER_ADDR_W-1:0] in_address [CORES_COUNT],
  input  logic [CORES_COUNT-1:0]   in_valid,
  input  logic                     flush,
  input  logic                     clear_overflow,
  output logic [BUFFER_ADDR_W-1:0] avm_address,
  output logic [COLOR_WIDTH-1:0]   avm_writedata,
  output logic                     avm_write,
  input  logic                     avm_waitrequest,
  output logic [CORES_COUNT-1:0]   overflow,
  output logic [15:0]              drop_count,
  output logic [31:0]              write_count,
  output logic                     idle
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned IDX_W = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;
  localparam int unsigned BYTES = COLOR_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(CORES_COUNT + 1);

  typedef struct packed {
    logic [BUFFER_ADDR_W-1:0] addr;
    logic [COLOR_WIDTH-1:0]   data;
  } pixel_t;

  typedef enum logic {ST_IDLE, ST_WRITE} state_t;

  pixel_t                 mem    [CORES_COUNT][FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr [CORES_COUNT];
  logic [PTR_W:0]         rd_ptr [CORES_COUNT];
  logic [CORES_COUNT-1:0] empty, full, push, drop, pop;

  state_t           state, state_next;
  logic [IDX_W-1:0] rr_ptr, grant_idx, cand;
  logic             grant_found, do_grant, accept;
  pixel_t           head;
  logic [CNT_W-1:0] drop_n;
  logic [16:0]      drop_sum;

  // FIFO status; full is judged on the pointers at cycle start, so a same-cycle pop never makes room
  for (genvar i = 0; i < CORES_COUNT; i++) begin : g_status
    assign empty[i] = (wr_ptr[i] == rd_ptr[i]);
    assign full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                      (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
    assign push[i]  = in_valid[i] && !full[i] && !flush;
    assign drop[i]  = in_valid[i] && full[i] && !flush;
    assign pop[i]   = do_grant && (grant_idx == IDX_W'(i));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CORES_COUNT; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CORES_COUNT; i++) begin
        if (flush) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + (PTR_W + 1)'(1);
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + (PTR_W + 1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CORES_COUNT; i++) begin
      if (push[i]) mem[i][wr_ptr[i][PTR_W-1:0]] <= {in_address[i], in_data[i]};
    end
  end

  // Round-robin search: first non-empty core at or above rr_ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < CORES_COUNT; k++) begin
      cand = IDX_W'((32'(rr_ptr) + 32'(k)) % CORES_COUNT);
      if (!grant_found && !empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign head   = mem[grant_idx][rd_ptr[grant_idx][PTR_W-1:0]];
  assign accept = (state == ST_WRITE) && !avm_waitrequest;

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_found && !flush) begin
          do_grant   = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // a flushed in-flight write still completes, but nothing follows it
        if (accept) begin
          if (grant_found && !flush) do_grant   = 1'b1;
          else                       state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else begin
      state <= state_next;
      if (do_grant) begin
        avm_address   <= BUFFER_ADDR_W'(FB_BASE) + head.addr * BUFFER_ADDR_W'(BYTES);
        avm_writedata <= head.data;
        rr_ptr        <= (grant_idx == IDX_W'(CORES_COUNT - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  assign avm_write = (state == ST_WRITE);
  assign idle      = (state == ST_IDLE) && (&empty);

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < CORES_COUNT; i++) begin
      drop_n = drop_n + CNT_W'(drop[i]);
    end
    drop_sum = 17'(drop_count) + 17'(drop_n);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow    <= '0;
      drop_count  <= '0;
      write_count <= '0;
    end else begin
      if (flush)       write_count <= '0;
      else if (accept) write_count <= write_count + 32'd1;

      if (clear_overflow) begin
        overflow   <= '0;
        drop_count <= '0;
      end else if (|drop) begin
        overflow   <= overflow | drop;
        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

endmodule
